// File: rtl/store_lane_buffer.sv
// Store lane formatter and FIFO write buffer between MEM stage and data memory.
// Narrows SB/SH/SW into lane-aligned writes with strobes and flags misaligned stores.
module store_lane_buffer #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   input  logic [1:0]        st_op,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   output logic              st_ready,
   output logic              ades,
   output logic [ADDR_W-1:0] ades_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   output logic              buf_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [31:0]       data_q [DEPTH];
   logic [3:0]        strb_q [DEPTH];

   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ades_q, ades_d;
   logic [ADDR_W-1:0] ades_addr_q, ades_addr_d;

   logic [1:0]        a;
   logic              acc, mis, push, pop;
   logic [31:0]       fmt_data;
   logic [3:0]        fmt_strb;
   logic [ADDR_W-1:0] fmt_addr;

   assign a        = st_addr[1:0];
   assign st_ready = (cnt_q != FULL);
   assign acc      = st_valid & st_ready;
   assign mis      = ((st_op == 2'b01) & a[0]) |
                     ((st_op == 2'b10) & (a != 2'b00));
   assign push     = acc & ~mis & (st_op != 2'b11);
   assign pop      = mem_req & mem_ack;
   assign fmt_addr = {st_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      fmt_data = '0;
      fmt_strb = '0;
      case (st_op)
         2'b00: begin
            fmt_data = {4{st_data[7:0]}};
            fmt_strb = 4'b0001 << a;
         end
         2'b01: begin
            fmt_data = {2{st_data[15:0]}};
            fmt_strb = a[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            fmt_data = st_data;
            fmt_strb = 4'b1111;
         end
         default: begin
            fmt_data = '0;
            fmt_strb = '0;
         end
      endcase
   end

   always_comb begin
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      ades_d      = acc & mis;
      ades_addr_d = ades_addr_q;
      if (acc & mis)
         ades_addr_d = st_addr;
      if (push)
         wr_d = wr_q + PW'(1);
      if (pop)
         rd_d = rd_q + PW'(1);
      if (push & ~pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop & ~push)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         ades_q      <= 1'b0;
         ades_addr_q <= '0;
      end else begin
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         ades_q      <= ades_d;
         ades_addr_q <= ades_addr_d;
      end
   end

   // Payload needs no reset: it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push & ~rst) begin
         addr_q[wr_q] <= fmt_addr;
         data_q[wr_q] <= fmt_data;
         strb_q[wr_q] <= fmt_strb;
      end
   end

   assign mem_req   = (cnt_q != '0);
   assign buf_empty = ~mem_req;
   assign mem_addr  = mem_req ? addr_q[rd_q] : '0;
   assign mem_wdata = mem_req ? data_q[rd_q] : '0;
   assign mem_wstrb = mem_req ? strb_q[rd_q] : '0;
   assign ades      = ades_q;
   assign ades_addr = ades_addr_q;

endmodule

// File: tb/tb_store_lane_buffer.sv
// Randomized and directed checks of store_lane_buffer against a queue-based model.
// The model formats lanes arithmetically and tracks pending writes in program order.
module tb_store_lane_buffer;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        ades;
   logic [31:0] ades_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic        buf_empty;

   wr_t         q[$];
   logic        m_ades;
   logic [31:0] m_ades_addr;
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   store_lane_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_op     (st_op),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_ready  (st_ready),
      .ades      (ades),
      .ades_addr (ades_addr),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ack   (mem_ack),
      .buf_empty (buf_empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic wr_t fmt(input logic [1:0] op, input logic [31:0] ad,
                               input logic [31:0] d);
      wr_t w;
      int  lo;
      lo     = int'(ad % 4);
      w.addr = ad - (ad % 4);
      w.data = '0;
      w.strb = '0;
      if (op == 2'd0) begin
         w.data = (d % 256) * 32'h0101_0101;
         w.strb = 4'(1 << lo);
      end else if (op == 2'd1) begin
         w.data = (d % 65536) * 32'h0001_0001;
         w.strb = (lo >= 2) ? 4'hC : 4'h3;
      end else begin
         w.data = d;
         w.strb = 4'hF;
      end
      return w;
   endfunction

   task automatic compare_all();
      wr_t h;
      chk("mem_req", mem_req, q.size() != 0);
      chk("buf_empty", buf_empty, q.size() == 0);
      chk("st_ready", st_ready, q.size() != DEPTH);
      chk("ades", ades, m_ades);
      chk("ades_addr", ades_addr, m_ades_addr);
      h = '0;
      if (q.size() != 0)
         h = q[0];
      chk("mem_addr", mem_addr, h.addr);
      chk("mem_wdata", mem_wdata, h.data);
      chk("mem_wstrb", mem_wstrb, h.strb);
   endtask

   // Drive one cycle at the current falling edge, advance the model, compare next.
   task automatic cyc(input bit r, input bit v, input logic [1:0] op,
                      input logic [31:0] ad, input logic [31:0] d,
                      input bit ack);
      bit acc, bad;
      rst      = r;
      st_valid = v;
      st_op    = op;
      st_addr  = ad;
      st_data  = d;
      mem_ack  = ack;
      if (r) begin
         q.delete();
         m_ades      = 1'b0;
         m_ades_addr = '0;
      end else begin
         acc    = v && (q.size() < DEPTH);
         bad    = (op == 2'd1 && ad % 2 != 0) || (op == 2'd2 && ad % 4 != 0);
         m_ades = acc && bad;
         if (acc && bad)
            m_ades_addr = ad;
         if (q.size() != 0 && ack)
            void'(q.pop_front());
         if (acc && !bad && op != 2'd3)
            q.push_back(fmt(op, ad, d));
      end
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst         = 1'b1;
      st_valid    = 1'b0;
      st_op       = '0;
      st_addr     = '0;
      st_data     = '0;
      mem_ack     = 1'b0;
      m_ades      = 1'b0;
      m_ades_addr = '0;
      repeat (2) @(negedge clk);

      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_empty", buf_empty, 1'b1);

      cyc(0, 1, 2'd0, 32'h1003, 32'hAABBCCDD, 0);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_data", mem_wdata, 32'hDDDDDDDD);
      chk("sb_strb", mem_wstrb, 4'b1000);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 2'd1, 32'h2002, 32'h12345678, 0);
      chk("sh_data", mem_wdata, 32'h56785678);
      chk("sh_strb", mem_wstrb, 4'b1100);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 2'd2, 32'h3000, 32'hCAFEF00D, 0);
      chk("sw_strb", mem_wstrb, 4'b1111);
      cyc(0, 0, 0, 0, 0, 1);

      cyc(0, 1, 2'd2, 32'h4001, 32'h1, 1);
      chk("sw_ades", ades, 1'b1);
      chk("sw_badv", ades_addr, 32'h4001);
      chk("sw_noreq", mem_req, 1'b0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("ades_pulse", ades, 1'b0);
      chk("badv_held", ades_addr, 32'h4001);
      cyc(0, 1, 2'd1, 32'h4001, 32'h2, 1);
      chk("sh_ades", ades, 1'b1);
      chk("sh_noreq", mem_req, 1'b0);
      cyc(0, 1, 2'd3, 32'h4003, 32'h3, 1);
      chk("rsv_noreq", mem_req, 1'b0);
      chk("rsv_noades", ades, 1'b0);

      cyc(0, 1, 2'd2, 32'h5000, 32'h11, 0);
      cyc(0, 1, 2'd2, 32'h5004, 32'h22, 0);
      chk("full_rdy", st_ready, 1'b0);
      cyc(0, 1, 2'd2, 32'h5008, 32'h33, 0);
      chk("held_head", mem_addr, 32'h5000);
      cyc(0, 1, 2'd2, 32'h5008, 32'h33, 1);
      chk("full_ack_head", mem_addr, 32'h5004);
      chk("full_ack_rdy", st_ready, 1'b1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("drained", buf_empty, 1'b1);

      cyc(0, 1, 2'd2, 32'h6000, 32'h44, 0);
      cyc(0, 1, 2'd2, 32'h6004, 32'h55, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("mid_rst_req", mem_req, 1'b0);
      chk("mid_rst_empty", buf_empty, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ad;
         ad = {$urandom_range(0, 15), 16'h0, 4'h0, 4'h0} | 32'($urandom_range(0, 255));
         cyc($urandom_range(0, 99) == 0,
             $urandom_range(0, 9) < 7,
             2'($urandom_range(0, 3)),
             ad,
             $urandom,
             $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
